// File: rtl/io_port_checker.sv
// ---------------------------------------------------------------------------
// io_port_checker
//
// Cycle-bounded self-checking monitor for CPU I/O port writes. It watches the
// CPU address/data buses and the DI strobe. Every write to one of NCHAN
// consecutive ports (BASE_ADDR .. BASE_ADDR+NCHAN-1) is compared against a
// per-port arithmetic sequence (EXPECT_START, then +EXPECT_STEP per write).
// It counts writes and mismatches, latches the first failure, and reports
// done/pass once MAX_CYCLES clocks have elapsed or the run is aborted.
//
// Ports
//   clk_i              clock, rising edge
//   reset_i            synchronous, active-high reset
//   addr_i             CPU address bus
//   bus_i              CPU data bus
//   DI_i               device-input strobe (CPU write to I/O)
//   start_i            one-clock pulse that begins a run (from IDLE or DONE)
//   abort_i            ends a run early
//   rd_chan_i          channel select for rd_count_o
//   rd_count_o         write count of rd_chan_i, 0 when rd_chan_i >= NCHAN
//   busy_o             a run is in progress
//   done_o             the run has finished, results are held
//   pass_o             no mismatches and enough writes (valid with done_o)
//   cycles_o           clocks elapsed in the current/last run
//   total_count_o      valid writes over all channels
//   err_count_o        mismatching writes
//   first_err_chan_o   channel of the first mismatch
//   first_err_got_o    bus value of the first mismatch
//   first_err_exp_o    expected value of the first mismatch
// ---------------------------------------------------------------------------
module io_port_checker #(
  parameter int WIDTH        = 16,
  parameter int NCHAN        = 2,
  parameter int BASE_ADDR    = 0,
  parameter int EXPECT_START = 0,
  parameter int EXPECT_STEP  = 1,
  parameter int MAX_CYCLES   = 2000,
  parameter int MIN_OUTPUTS  = 1,
  parameter int CNT_W        = 16,
  localparam int CHW         = $clog2(NCHAN) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] bus_i,
  input  logic             DI_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CHW-1:0]   rd_chan_i,
  output logic [CNT_W-1:0] rd_count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic [CNT_W-1:0] total_count_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CHW-1:0]   first_err_chan_o,
  output logic [WIDTH-1:0] first_err_got_o,
  output logic [WIDTH-1:0] first_err_exp_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_OUT    = CNT_W'(MIN_OUTPUTS);
  localparam logic [WIDTH:0]   BASE_EXT   = (WIDTH+1)'(BASE_ADDR);
  localparam logic [WIDTH:0]   NCHAN_EXT  = (WIDTH+1)'(NCHAN);
  localparam logic [WIDTH-1:0] START_V    = WIDTH'(EXPECT_START);
  localparam logic [WIDTH-1:0] STEP_V     = WIDTH'(EXPECT_STEP);

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] cycles_q;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] cnt_q [NCHAN];
  logic [WIDTH-1:0] exp_q [NCHAN];
  logic [CHW-1:0]   firstErrChan_q;
  logic [WIDTH-1:0] firstErrGot_q;
  logic [WIDTH-1:0] firstErrExp_q;

  logic [WIDTH:0]   offset;
  logic [CHW-1:0]   hitChan;
  logic             hit;
  logic             mismatch;
  logic             endRun;
  logic [WIDTH-1:0] expSel;
  logic [CNT_W-1:0] cycles_d;
  logic [CNT_W-1:0] total_d;
  logic [CNT_W-1:0] err_d;

  // Counters stick at their maximum instead of wrapping, so a saturated
  // error count can never roll back to zero and fake a pass.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Hit decode and next-value arithmetic for the run counters. The port
  // offset is taken one bit wider than the bus so that addresses below
  // BASE_ADDR borrow into the top bit and fall out of range, rather than
  // aliasing onto a channel when BASE_ADDR sits near the top of the space.
  always_comb begin
    offset   = {1'b0, addr_i} - BASE_EXT;
    hitChan  = offset[CHW-1:0];
    hit      = (state_q == RUN) && DI_i && (offset < NCHAN_EXT);
    expSel   = START_V;
    for (int i = 0; i < NCHAN; i++) begin
      if (hitChan == CHW'(i)) begin
        expSel = exp_q[i];
      end
    end
    mismatch = hit && (bus_i != expSel);
    endRun   = (cycles_q == LAST_CYCLE) || abort_i;
    cycles_d = satInc(cycles_q);
    total_d  = hit ? satInc(total_q) : total_q;
    err_d    = mismatch ? satInc(err_q) : err_q;
  end

  // Per-channel count readback; channel numbers past NCHAN read as zero.
  always_comb begin
    rd_count_o = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (rd_chan_i == CHW'(i)) begin
        rd_count_o = cnt_q[i];
      end
    end
  end

  // Run controller. IDLE and DONE both wait for start, which clears every
  // counter and rewinds the expected sequences. In RUN each clock bumps the
  // cycle counter and applies any hit; the edge that finishes the run (by
  // timeout or abort) still applies its hit, and pass is computed from the
  // post-update counts so that last write is included. The expected value
  // advances on every hit, good or bad, so one bad write costs one error.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      cycles_q       <= '0;
      total_q        <= '0;
      err_q          <= '0;
      firstErrChan_q <= '0;
      firstErrGot_q  <= '0;
      firstErrExp_q  <= '0;
      for (int i = 0; i < NCHAN; i++) begin
        cnt_q[i] <= '0;
        exp_q[i] <= START_V;
      end
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q        <= RUN;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            cycles_q       <= '0;
            total_q        <= '0;
            err_q          <= '0;
            firstErrChan_q <= '0;
            firstErrGot_q  <= '0;
            firstErrExp_q  <= '0;
            for (int i = 0; i < NCHAN; i++) begin
              cnt_q[i] <= '0;
              exp_q[i] <= START_V;
            end
          end
        end
        RUN: begin
          cycles_q <= cycles_d;
          total_q  <= total_d;
          err_q    <= err_d;
          for (int i = 0; i < NCHAN; i++) begin
            if (hit && (hitChan == CHW'(i))) begin
              cnt_q[i] <= satInc(cnt_q[i]);
              exp_q[i] <= exp_q[i] + STEP_V;
            end
          end
          if (mismatch && (err_q == '0)) begin
            firstErrChan_q <= hitChan;
            firstErrGot_q  <= bus_i;
            firstErrExp_q  <= expSel;
          end
          if (endRun) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0) && (total_d >= MIN_OUT);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign cycles_o         = cycles_q;
  assign total_count_o    = total_q;
  assign err_count_o      = err_q;
  assign first_err_chan_o = firstErrChan_q;
  assign first_err_got_o  = firstErrGot_q;
  assign first_err_exp_o  = firstErrExp_q;

endmodule
